// File: rtl/decode_ctrl_stage.sv
// Registered ID/EX control decoder with valid/ready handshake, load-use
// interlock, multi-cycle MUL/DIV issue blocking, flush and illegal flagging.
module decode_ctrl_stage #(
    parameter bit          EN_M       = 1'b1,
    parameter int unsigned MUL_CYCLES = 1,
    parameter int unsigned DIV_CYCLES = 32,
    parameter bit          EN_CSR     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_0,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       regWrite,
    output logic       memWrite,
    output logic       branch,
    output logic       jump,
    output logic       useF7,
    output logic       useRegAdd,
    output logic       aluSrcB,
    output logic       csrOp,
    output logic       mulDiv,
    output logic       illegal,
    output logic [2:0] immCntrl,
    output logic [1:0] aluSrcA,
    output logic [1:0] regSrc,
    output logic [4:0] out_rs1,
    output logic [4:0] out_rs2,
    output logic [4:0] out_rd
);

    localparam int unsigned MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_IARI  = 5'b00100;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_CSR   = 5'b11100;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_ld;

    logic       regWrite_d, memWrite_d, branch_d, jump_d, useF7_d, useRegAdd_d;
    logic       aluSrcB_d, csrOp_d, mulDiv_d, illegal_d;
    logic [2:0] immCntrl_d;
    logic [1:0] aluSrcA_d, regSrc_d;
    logic       use_rs1, use_rs2;
    logic       hazard, accept;

    // Instruction decode into next-state control fields
    always_comb begin
        regWrite_d  = 1'b1;
        memWrite_d  = 1'b0;
        branch_d    = 1'b0;
        jump_d      = 1'b0;
        useF7_d     = 1'b0;
        useRegAdd_d = 1'b0;
        csrOp_d     = 1'b0;
        mulDiv_d    = 1'b0;
        illegal_d   = 1'b0;
        immCntrl_d  = 3'd0;
        aluSrcA_d   = 2'd0;
        regSrc_d    = 2'd0;
        use_rs1     = 1'b1;
        use_rs2     = 1'b0;
        case (op)
            OP_R: begin
                use_rs2 = 1'b1;
                if (funct7_0) begin
                    if (EN_M) mulDiv_d = 1'b1;
                    else      illegal_d = 1'b1;
                end else begin
                    useF7_d = 1'b1;
                end
            end
            OP_IARI: begin
                if (funct3[1:0] == 2'b01) begin
                    immCntrl_d = 3'd1;
                    useF7_d    = 1'b1;
                end else begin
                    immCntrl_d = 3'd2;
                end
            end
            OP_LOAD: begin
                regSrc_d    = 2'd1;
                immCntrl_d  = 3'd2;
                useRegAdd_d = 1'b1;
            end
            OP_STORE: begin
                memWrite_d  = 1'b1;
                regWrite_d  = 1'b0;
                immCntrl_d  = 3'd3;
                useRegAdd_d = 1'b1;
                use_rs2     = 1'b1;
            end
            OP_BR: begin
                branch_d   = 1'b1;
                regWrite_d = 1'b0;
                immCntrl_d = 3'd4;
                use_rs2    = 1'b1;
            end
            OP_JAL: begin
                jump_d     = 1'b1;
                regSrc_d   = 2'd2;
                immCntrl_d = 3'd6;
                use_rs1    = 1'b0;
            end
            OP_JALR: begin
                jump_d      = 1'b1;
                regSrc_d    = 2'd2;
                immCntrl_d  = 3'd2;
                useRegAdd_d = 1'b1;
            end
            OP_AUIPC: begin
                immCntrl_d  = 3'd5;
                useRegAdd_d = 1'b1;
                aluSrcA_d   = 2'd1;
                use_rs1     = 1'b0;
            end
            OP_LUI: begin
                immCntrl_d  = 3'd5;
                useRegAdd_d = 1'b1;
                aluSrcA_d   = 2'd3;
                use_rs1     = 1'b0;
            end
            OP_CSR: begin
                if (EN_CSR) begin
                    csrOp_d   = 1'b1;
                    aluSrcA_d = 2'd3;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            default: illegal_d = 1'b1;
        endcase
        // An illegal instruction carries only its flag downstream
        if (illegal_d) begin
            regWrite_d  = 1'b0;
            memWrite_d  = 1'b0;
            branch_d    = 1'b0;
            jump_d      = 1'b0;
            useF7_d     = 1'b0;
            useRegAdd_d = 1'b0;
            csrOp_d     = 1'b0;
            mulDiv_d    = 1'b0;
            immCntrl_d  = 3'd0;
            aluSrcA_d   = 2'd0;
            regSrc_d    = 2'd0;
        end
        aluSrcB_d = !branch_d && (immCntrl_d != 3'd0);
    end

    // Load-use interlock against the held entry, and the issue handshake
    always_comb begin
        hazard = out_valid && (regSrc == 2'd1) && (out_rd != 5'd0) &&
                 (((out_rd == rs1) && use_rs1) || ((out_rd == rs2) && use_rs2));
        in_ready = !rst && !flush && (state_q == S_IDLE) && !hazard &&
                   (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        cnt_ld   = funct3[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    end

    // Output register, valid tracking and IDLE/BUSY issue-blocking FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            regWrite  <= 1'b0;
            memWrite  <= 1'b0;
            branch    <= 1'b0;
            jump      <= 1'b0;
            useF7     <= 1'b0;
            useRegAdd <= 1'b0;
            aluSrcB   <= 1'b0;
            csrOp     <= 1'b0;
            mulDiv    <= 1'b0;
            illegal   <= 1'b0;
            immCntrl  <= 3'd0;
            aluSrcA   <= 2'd0;
            regSrc    <= 2'd0;
            out_rs1   <= 5'd0;
            out_rs2   <= 5'd0;
            out_rd    <= 5'd0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                regWrite  <= regWrite_d;
                memWrite  <= memWrite_d;
                branch    <= branch_d;
                jump      <= jump_d;
                useF7     <= useF7_d;
                useRegAdd <= useRegAdd_d;
                aluSrcB   <= aluSrcB_d;
                csrOp     <= csrOp_d;
                mulDiv    <= mulDiv_d;
                illegal   <= illegal_d;
                immCntrl  <= immCntrl_d;
                aluSrcA   <= aluSrcA_d;
                regSrc    <= regSrc_d;
                out_rs1   <= rs1;
                out_rs2   <= rs2;
                out_rd    <= rd;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (state_q == S_BUSY) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_q <= S_IDLE;
            end else if (accept && mulDiv_d && (cnt_ld != '0)) begin
                cnt_q   <= cnt_ld;
                state_q <= S_BUSY;
            end
        end
    end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: decode fields, interlock, busy window,
// backpressure, flush and reset.
module tb_decode_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready, funct7_0;
    logic [4:0] op, rs1, rs2, rd;
    logic [2:0] funct3;

    logic       in_ready, out_valid;
    logic       regWrite, memWrite, branch, jump, useF7, useRegAdd, aluSrcB, csrOp, mulDiv, illegal;
    logic [2:0] immCntrl;
    logic [1:0] aluSrcA, regSrc;
    logic [4:0] out_rs1, out_rs2, out_rd;

    // Second instance: M extension and CSR disabled
    logic       n_in_ready, n_out_valid;
    logic       n_regWrite, n_memWrite, n_branch, n_jump, n_useF7, n_useRegAdd, n_aluSrcB, n_csrOp, n_mulDiv, n_illegal;
    logic [2:0] n_immCntrl;
    logic [1:0] n_aluSrcA, n_regSrc;
    logic [4:0] n_out_rs1, n_out_rs2, n_out_rd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.EN_M(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(32), .EN_CSR(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct3(funct3), .funct7_0(funct7_0), .rs1(rs1), .rs2(rs2), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .regWrite(regWrite), .memWrite(memWrite), .branch(branch), .jump(jump), .useF7(useF7),
        .useRegAdd(useRegAdd), .aluSrcB(aluSrcB), .csrOp(csrOp), .mulDiv(mulDiv), .illegal(illegal),
        .immCntrl(immCntrl), .aluSrcA(aluSrcA), .regSrc(regSrc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd)
    );

    decode_ctrl_stage #(.EN_M(1'b0), .MUL_CYCLES(1), .DIV_CYCLES(32), .EN_CSR(1'b0)) dut_nomc (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .op(op), .funct3(funct3), .funct7_0(funct7_0), .rs1(rs1), .rs2(rs2), .rd(rd),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .regWrite(n_regWrite), .memWrite(n_memWrite), .branch(n_branch), .jump(n_jump), .useF7(n_useF7),
        .useRegAdd(n_useRegAdd), .aluSrcB(n_aluSrcB), .csrOp(n_csrOp), .mulDiv(n_mulDiv), .illegal(n_illegal),
        .immCntrl(n_immCntrl), .aluSrcA(n_aluSrcA), .regSrc(n_regSrc),
        .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_rd(n_out_rd)
    );

    // Control bundle: rw mw br jp f7 ra sb csr md ill imm[2:0] A[1:0] R[1:0]
    wire [16:0] ctl   = {regWrite, memWrite, branch, jump, useF7, useRegAdd, aluSrcB, csrOp,
                         mulDiv, illegal, immCntrl, aluSrcA, regSrc};
    wire [16:0] n_ctl = {n_regWrite, n_memWrite, n_branch, n_jump, n_useF7, n_useRegAdd, n_aluSrcB,
                         n_csrOp, n_mulDiv, n_illegal, n_immCntrl, n_aluSrcA, n_regSrc};

    // Hand-decoded expected control bundles
    localparam logic [16:0] C_ADDI = {10'b1000001000, 3'd2, 2'd0, 2'd0};
    localparam logic [16:0] C_LW   = {10'b1000011000, 3'd2, 2'd0, 2'd1};
    localparam logic [16:0] C_ADD  = {10'b1000100000, 3'd0, 2'd0, 2'd0};
    localparam logic [16:0] C_LUI  = {10'b1000011000, 3'd5, 2'd3, 2'd0};
    localparam logic [16:0] C_SW   = {10'b0100011000, 3'd3, 2'd0, 2'd0};
    localparam logic [16:0] C_MD   = {10'b1000000010, 3'd0, 2'd0, 2'd0};
    localparam logic [16:0] C_CSR  = {10'b1000000100, 3'd0, 2'd3, 2'd0};
    localparam logic [16:0] C_ILL  = {10'b0000000001, 3'd0, 2'd0, 2'd0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] o, input logic [2:0] f3, input logic f7,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        in_valid = v; op = o; funct3 = f3; funct7_0 = f7; rs1 = a; rs2 = b; rd = d;
        #1;
    endtask

    initial begin
        int lo;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 5'b00000, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ctl", 32'(ctl), 32'd0);
        check("rst_rd", 32'(out_rd), 32'd0);
        rst = 1'b0;

        // ADDI
        drive(1'b1, 5'b00100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd3);
        check("addi_ready", 32'(in_ready), 32'd1);
        tick();
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_ctl", 32'(ctl), 32'(C_ADDI));
        check("addi_rd", 32'(out_rd), 32'd3);

        // Load-use on rs1: one bubble
        drive(1'b1, 5'b00000, 3'b010, 1'b0, 5'd2, 5'd0, 5'd5);
        tick();
        check("lw_ctl", 32'(ctl), 32'(C_LW));
        drive(1'b1, 5'b01100, 3'b000, 1'b0, 5'd5, 5'd6, 5'd7);
        check("lu_ready_lo", 32'(in_ready), 32'd0);
        tick();
        check("lu_bubble", 32'(out_valid), 32'd0);
        check("lu_ready_hi", 32'(in_ready), 32'd1);
        tick();
        check("lu_add_valid", 32'(out_valid), 32'd1);
        check("lu_add_ctl", 32'(ctl), 32'(C_ADD));
        check("lu_add_rd", 32'(out_rd), 32'd7);

        // Load to x0: no interlock
        drive(1'b1, 5'b00000, 3'b010, 1'b0, 5'd2, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'b01100, 3'b000, 1'b0, 5'd0, 5'd0, 5'd8);
        check("x0_ready", 32'(in_ready), 32'd1);
        tick();
        check("x0_rd", 32'(out_rd), 32'd8);

        // LUI ignores rs1, so no interlock on it
        drive(1'b1, 5'b00000, 3'b010, 1'b0, 5'd2, 5'd0, 5'd9);
        tick();
        drive(1'b1, 5'b01101, 3'b000, 1'b0, 5'd9, 5'd0, 5'd10);
        check("lui_ready", 32'(in_ready), 32'd1);
        tick();
        check("lui_ctl", 32'(ctl), 32'(C_LUI));

        // Store uses rs2: interlocks
        drive(1'b1, 5'b00000, 3'b010, 1'b0, 5'd2, 5'd0, 5'd11);
        tick();
        drive(1'b1, 5'b01000, 3'b010, 1'b0, 5'd1, 5'd11, 5'd0);
        check("sw_ready_lo", 32'(in_ready), 32'd0);
        tick();
        check("sw_bubble", 32'(out_valid), 32'd0);
        tick();
        check("sw_ctl", 32'(ctl), 32'(C_SW));

        // DIV blocks issue for DIV_CYCLES-1 cycles
        drive(1'b1, 5'b01100, 3'b100, 1'b1, 5'd1, 5'd2, 5'd12);
        tick();
        check("div_ctl", 32'(ctl), 32'(C_MD));
        drive(1'b0, 5'b00100, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        lo = 0;
        while (!in_ready && lo < 40) begin
            lo++;
            tick();
        end
        check("div_block_cycles", 32'(lo), 32'd31);

        // MUL with one cycle: no stall
        drive(1'b1, 5'b01100, 3'b000, 1'b1, 5'd1, 5'd2, 5'd13);
        tick();
        check("mul_ctl", 32'(ctl), 32'(C_MD));
        check("nomc_mul_illegal", 32'(n_ctl), 32'(C_ILL));
        out_ready = 1'b0;
        drive(1'b1, 5'b00100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd14);
        check("mul_no_stall", 32'(dut.state_q), 32'd0);

        // Backpressure: held entry stable, not ready
        for (int i = 0; i < 4; i++) begin
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_stable", {10'd0, out_valid, out_rd, ctl}, {10'd0, 1'b1, 5'd13, C_MD});
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_next_rd", 32'(out_rd), 32'd14);
        check("bp_next_ctl", 32'(ctl), 32'(C_ADDI));

        // Flush in cycle 10 of a DIV busy window
        drive(1'b1, 5'b01100, 3'b101, 1'b1, 5'd1, 5'd2, 5'd15);
        tick();
        drive(1'b0, 5'b00100, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        drive(1'b1, 5'b00100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd16);
        check("fl_busy_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 5'b00100, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        check("fl_busy_valid", 32'(out_valid), 32'd0);
        check("fl_busy_ready_hi", 32'(in_ready), 32'd1);

        // Flush beats an otherwise legal accept
        flush = 1'b1;
        drive(1'b1, 5'b00100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd17);
        check("fl_idle_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 5'b00100, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        check("fl_idle_valid", 32'(out_valid), 32'd0);

        // Unknown opcode
        drive(1'b1, 5'b11111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd18);
        tick();
        check("ill_ctl", 32'(ctl), 32'(C_ILL));
        check("ill_valid", 32'(out_valid), 32'd1);

        // CSR enabled vs disabled
        drive(1'b1, 5'b11100, 3'b001, 1'b0, 5'd1, 5'd0, 5'd19);
        check("ill_no_stall", 32'(in_ready), 32'd1);
        tick();
        check("csr_ctl", 32'(ctl), 32'(C_CSR));
        check("nocsr_ctl", 32'(n_ctl), 32'(C_ILL));
        check("nocsr_valid", 32'(n_out_valid), 32'd1);

        // Reset during BUSY
        drive(1'b1, 5'b01100, 3'b110, 1'b1, 5'd1, 5'd2, 5'd20);
        tick();
        drive(1'b0, 5'b00100, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
        tick(); tick();
        check("busy_before_rst", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        check("rst_busy_valid", 32'(out_valid), 32'd0);
        check("rst_busy_ctl", 32'(ctl), 32'd0);
        check("rst_busy_idx", {17'd0, out_rs1, out_rs2, out_rd}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_busy_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
